echo_indication_input: RTL and testbench

- Receive end of the Echo indication pipe.
- Accepts tagged indication messages from the PipeIn-style enqueue interface, buffers them in a 2-entry FIFO, decodes the tag, and re-issues valid messages as `heard(meth, v)` calls on the EchoIndication client interface.
- Messages with unknown tags are consumed and counted, never forwarded.
- Sits on the host/software side, opposite the indication serializer.

---
 rtl/echo_indication_input.sv | 142 ++++++++++++++
 tb/tb_echo_indication_input.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_indication_input.sv
`default_nettype none
// ============================================================================
//  Module      : echo_indication_input
//  Description : Receive end of the Echo indication pipe. Tagged indication
//                messages arrive on a PipeIn-style enqueue interface. Those
//                carrying the `heard` tag go into a 2-entry FIFO and are
//                re-issued as heard(meth, v) calls on the EchoIndication
//                client interface. Messages with any other tag are consumed,
//                counted in a saturating counter and never forwarded.
//
//  Ports       : CLK            clock, all state updates on the rising edge
//                nRST           synchronous active-low reset
//                pipe_enq_ENA   sender presents a message this cycle
//                pipe_enq_v     message {tag, meth, v}, tag at the MSBs
//                pipe_enq_RDY   block can accept a message
//                ind_heard_ENA  a buffered heard call is offered
//                ind_heard_meth meth argument of the head entry
//                ind_heard_v    v argument of the head entry
//                ind_heard_RDY  consumer accepts the call
//                drop_count     messages discarded for an unknown tag
//                busy           FIFO non-empty
//
//  Revision    : 1.0 - initial release
// ============================================================================
module echo_indication_input #(
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 16,
    parameter int HEARD_TAG = 1,
    parameter int CNT_W     = 16
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      pipe_enq_ENA,
    input  logic [TAG_W+2*DATA_W-1:0] pipe_enq_v,
    output logic                      pipe_enq_RDY,
    output logic                      ind_heard_ENA,
    output logic [DATA_W-1:0]         ind_heard_meth,
    output logic [DATA_W-1:0]         ind_heard_v,
    input  logic                      ind_heard_RDY,
    output logic [CNT_W-1:0]          drop_count,
    output logic                      busy
);

    localparam int               MSG_W       = TAG_W + 2 * DATA_W;
    localparam logic [TAG_W-1:0] c_HEARD_TAG = TAG_W'(HEARD_TAG);
    localparam logic [1:0]       c_FULL      = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_meth [2];
    logic [DATA_W-1:0] r_v    [2];
    logic              r_wp;
    logic              r_rp;
    logic [1:0]        r_count;
    logic [CNT_W-1:0]  r_drop_count;

    // ------------------------------------------------------------------
    // Message field split and handshake decode
    // ------------------------------------------------------------------
    logic [TAG_W-1:0]  w_tag;
    logic [DATA_W-1:0] w_meth;
    logic [DATA_W-1:0] w_v;
    logic              w_enq;
    logic              w_is_heard;
    logic              w_store;
    logic              w_drop;
    logic              w_deq;

    assign w_tag  = pipe_enq_v[MSG_W-1 -: TAG_W];
    assign w_meth = pipe_enq_v[2*DATA_W-1 -: DATA_W];
    assign w_v    = pipe_enq_v[DATA_W-1:0];

    // No bypass when full: a dequeue in the same cycle does not open a slot,
    // which keeps RDY free of any path from the consumer side.
    assign pipe_enq_RDY = nRST && (r_count != c_FULL);

    assign w_enq      = pipe_enq_ENA && pipe_enq_RDY;
    assign w_is_heard = (w_tag == c_HEARD_TAG);
    assign w_store    = w_enq && w_is_heard;
    assign w_drop     = w_enq && !w_is_heard;
    assign w_deq      = ind_heard_ENA && ind_heard_RDY;

    // ------------------------------------------------------------------
    // Outputs, all driven from registers (1-cycle latency, no v->heard path)
    // ------------------------------------------------------------------
    assign ind_heard_ENA  = (r_count != 2'd0);
    assign busy           = (r_count != 2'd0);
    assign ind_heard_meth = r_meth[r_rp];
    assign ind_heard_v    = r_v[r_rp];
    assign drop_count     = r_drop_count;

    // ------------------------------------------------------------------
    // Storage: contents are intentionally left untouched by reset; the
    // count/pointer reset alone makes any stale data unreachable.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (w_store) begin
            r_meth[r_wp] <= w_meth;
            r_v[r_wp]    <= w_v;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy and drop counter
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_wp         <= 1'b0;
            r_rp         <= 1'b0;
            r_count      <= 2'd0;
            r_drop_count <= '0;
        end else begin
            if (w_store) begin
                r_wp <= ~r_wp;
            end
            if (w_deq) begin
                r_rp <= ~r_rp;
            end
            // A dropped message never touches the occupancy, so only the
            // stored/dequeued pair matters here.
            case ({w_store, w_deq})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_drop_count != {CNT_W{1'b1}})) begin
                r_drop_count <= r_drop_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge CLK) begin
        if (nRST && w_drop) begin
            $display("echo_indication_input: dropped message with tag 0x%h", w_tag);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_echo_indication_input.sv
`default_nettype none
// ============================================================================
//  Module      : tb_echo_indication_input
//  Description : Scoreboard bench for echo_indication_input. Stimulus pushes
//                the expected heard(meth, v) call when a tag=1 message is
//                accepted; a monitor pops and compares on every dequeue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_echo_indication_input;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 16;
    localparam int CNT_W  = 16;
    localparam int MSG_W  = TAG_W + 2 * DATA_W;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              pipe_enq_ENA;
    logic [MSG_W-1:0]  pipe_enq_v;
    logic              pipe_enq_RDY;
    logic              ind_heard_ENA;
    logic [DATA_W-1:0] ind_heard_meth;
    logic [DATA_W-1:0] ind_heard_v;
    logic              ind_heard_RDY;
    logic [CNT_W-1:0]  drop_count;
    logic              busy;

    // Second instance with a narrow drop counter for the saturation check
    logic              sat_ENA;
    logic [MSG_W-1:0]  sat_v;
    logic              sat_RDY;
    logic              sat_heard_ENA;
    logic [DATA_W-1:0] sat_heard_meth;
    logic [DATA_W-1:0] sat_heard_v;
    logic [3:0]        sat_drop;
    logic              sat_busy;

    always #5 CLK = ~CLK;

    echo_indication_input #(.DATA_W(DATA_W), .TAG_W(TAG_W), .HEARD_TAG(1), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST),
        .pipe_enq_ENA(pipe_enq_ENA), .pipe_enq_v(pipe_enq_v), .pipe_enq_RDY(pipe_enq_RDY),
        .ind_heard_ENA(ind_heard_ENA), .ind_heard_meth(ind_heard_meth),
        .ind_heard_v(ind_heard_v), .ind_heard_RDY(ind_heard_RDY),
        .drop_count(drop_count), .busy(busy)
    );

    echo_indication_input #(.DATA_W(DATA_W), .TAG_W(TAG_W), .HEARD_TAG(1), .CNT_W(4)) dut_sat (
        .CLK(CLK), .nRST(nRST),
        .pipe_enq_ENA(sat_ENA), .pipe_enq_v(sat_v), .pipe_enq_RDY(sat_RDY),
        .ind_heard_ENA(sat_heard_ENA), .ind_heard_meth(sat_heard_meth),
        .ind_heard_v(sat_heard_v), .ind_heard_RDY(1'b1),
        .drop_count(sat_drop), .busy(sat_busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_heard = 0;
    logic [2*DATA_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every fired heard call must match the scoreboard head.
    always @(negedge CLK) begin
        if (nRST && ind_heard_ENA && ind_heard_RDY) begin
            n_heard++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL heard_unexpected: got meth=0x%0h v=0x%0h expected no call",
                         ind_heard_meth, ind_heard_v);
            end else begin
                logic [2*DATA_W-1:0] e;
                e = exp_q.pop_front();
                if ({ind_heard_meth, ind_heard_v} !== e) begin
                    n_err++;
                    $display("FAIL heard_data: got meth=0x%0h v=0x%0h expected meth=0x%0h v=0x%0h",
                             ind_heard_meth, ind_heard_v, e[2*DATA_W-1:DATA_W], e[DATA_W-1:0]);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    // waits = cycles spent with RDY low before acceptance.
    task automatic send(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] meth,
                        input logic [DATA_W-1:0] v, output int waits);
        bit ok;
        ok = 1'b0;
        waits = 0;
        pipe_enq_ENA = 1'b1;
        pipe_enq_v   = {tag, meth, v};
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (pipe_enq_RDY) begin
                if (tag == 16'd1) exp_q.push_back({meth, v});
                ok = 1'b1;
                @(posedge CLK);
                #1;
                break;
            end
            waits++;
            @(posedge CLK);
            #1;
        end
        pipe_enq_ENA = 1'b0;
        if (!ok) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && !ind_heard_ENA) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge CLK);
        #1;
        if (!ok) check("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int heard0;
        nRST = 1'b0;
        pipe_enq_ENA = 1'b0;
        pipe_enq_v = '0;
        ind_heard_RDY = 1'b0;
        sat_ENA = 1'b0;
        sat_v = '0;

        // ---- Reset state
        repeat (3) step();
        @(negedge CLK);
        check("rst_rdy", 64'(pipe_enq_RDY), 64'd0);
        check("rst_ena", 64'(ind_heard_ENA), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        step();
        nRST = 1'b1;
        @(negedge CLK);
        check("rel_rdy", 64'(pipe_enq_RDY), 64'd1);
        check("rel_ena", 64'(ind_heard_ENA), 64'd0);
        step();

        // ---- Single pass-through, 1-cycle latency
        ind_heard_RDY = 1'b1;
        send(16'd1, 32'h11, 32'hAB, w);
        @(negedge CLK);
        check("pass_ena", 64'(ind_heard_ENA), 64'd1);
        step();
        @(negedge CLK);
        check("pass_ena_after", 64'(ind_heard_ENA), 64'd0);
        check("pass_busy_after", 64'(busy), 64'd0);
        step();

        // ---- Backpressure and full
        ind_heard_RDY = 1'b0;
        send(16'd1, 32'h0, 32'd1, w);
        check("bp_wait1", 64'(w), 64'd0);
        send(16'd1, 32'h0, 32'd2, w);
        check("bp_wait2", 64'(w), 64'd0);
        pipe_enq_ENA = 1'b1;
        pipe_enq_v = {16'd1, 32'h0, 32'd3};
        @(negedge CLK);
        check("bp_full_rdy", 64'(pipe_enq_RDY), 64'd0);
        check("bp_full_busy", 64'(busy), 64'd1);
        step();
        @(negedge CLK);
        check("bp_hold_rdy", 64'(pipe_enq_RDY), 64'd0);
        step();
        ind_heard_RDY = 1'b1;
        send(16'd1, 32'h0, 32'd3, w);
        check("bp_accept_after_deq", 64'(w), 64'd1);
        drain();

        // ---- Streaming: one per cycle, never waits (occupancy stays <= 1)
        heard0 = n_heard;
        for (int i = 0; i < 8; i++) begin
            send(16'd1, 32'h100 + 32'(i), 32'(i), w);
            check("stream_wait", 64'(w), 64'd0);
        end
        drain();
        check("stream_calls", 64'(n_heard - heard0), 64'd8);

        // ---- Unknown tags interleaved
        heard0 = n_heard;
        send(16'd0,    32'h5, 32'h50, w);
        send(16'd1,    32'h6, 32'hA,  w);
        send(16'd2,    32'h7, 32'h70, w);
        send(16'hFFFF, 32'h8, 32'h80, w);
        send(16'd1,    32'h9, 32'hB,  w);
        drain();
        check("unk_drop", 64'(drop_count), 64'd3);
        check("unk_calls", 64'(n_heard - heard0), 64'd2);

        // ---- Saturation on the 4-bit counter instance
        sat_ENA = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sat_v = {16'(i + 2), 32'h0, 32'(i)};
            step();
            if (i == 9)  check("sat_drop_10", 64'(sat_drop), 64'd10);
            if (i == 14) check("sat_drop_15", 64'(sat_drop), 64'd15);
        end
        sat_ENA = 1'b0;
        @(negedge CLK);
        check("sat_drop_final", 64'(sat_drop), 64'd15);
        check("sat_no_calls", 64'(sat_busy), 64'd0);
        step();

        // ---- Reset mid-operation
        ind_heard_RDY = 1'b0;
        send(16'd1, 32'h21, 32'hC1, w);
        send(16'd1, 32'h22, 32'hC2, w);
        @(negedge CLK);
        check("mid_full_rdy", 64'(pipe_enq_RDY), 64'd0);
        check("mid_drop_before", 64'(drop_count), 64'd3);
        step();
        nRST = 1'b0;
        @(negedge CLK);
        check("mid_rst_rdy", 64'(pipe_enq_RDY), 64'd0);
        step();
        nRST = 1'b1;
        exp_q.delete();
        @(negedge CLK);
        check("mid_ena", 64'(ind_heard_ENA), 64'd0);
        check("mid_drop", 64'(drop_count), 64'd0);
        check("mid_rdy", 64'(pipe_enq_RDY), 64'd1);
        check("mid_busy", 64'(busy), 64'd0);
        ind_heard_RDY = 1'b1;
        heard0 = n_heard;
        repeat (3) step();
        check("mid_no_stale", 64'(n_heard - heard0), 64'd0);
        send(16'd1, 32'h33, 32'hD3, w);
        drain();
        check("mid_new_call", 64'(n_heard - heard0), 64'd1);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
